// File: rtl/uart_pkg.sv
// Shared UART constants for the receiver and transmitter.
package uart_pkg;

    // 115200 baud from a 100 MHz clock
    localparam logic [23:0] UART_CLOCKS_PER_BAUD = 24'd868;

    // Frame format shared by both directions
    localparam int UART_DATA_BITS = 8;
    localparam int UART_STOP_BITS = 1;

    // Transmitter setup: line held idle this many baud periods after reset
    localparam int UART_TX_IDLE_BAUDS = 2;

    // Half a bit period; the receiver waits this long to reach mid-bit
    function automatic logic [23:0] uart_half_period(input logic [23:0] cpb);
        return cpb >> 1;
    endfunction

endpackage

// File: rtl/uart_rx_lite.sv
// Lightweight UART receiver: 8N1, mid-bit sampling, one-cycle strobes for
// good bytes and for frames whose stop bit was sampled low.
module uart_rx_lite
    import uart_pkg::*;
#(
    parameter logic [23:0] CLOCKS_PER_BAUD = UART_CLOCKS_PER_BAUD
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_uart_rx,
    output logic       o_wr,
    output logic [7:0] o_data,
    output logic       o_frame_err,
    output logic       o_busy
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

    typedef enum logic [2:0] {
        IDLE      = ST_IDLE,
        START     = ST_START,
        DATA      = ST_DATA,
        STOP      = ST_STOP,
        WAIT_IDLE = ST_WAIT_IDLE
    } state_t;

    // Reload values: a period loaded with N-1 expires on the Nth edge
    localparam logic [23:0] LP_HALF_M1 = uart_half_period(CLOCKS_PER_BAUD) - 24'd1;
    localparam logic [23:0] LP_BAUD_M1 = CLOCKS_PER_BAUD - 24'd1;
    localparam logic [2:0]  LP_LAST_BIT = 3'(UART_DATA_BITS - 1);

    logic        r_rx_meta;
    logic        r_rx_s;
    state_t      r_state;
    logic [23:0] r_cnt;
    logic [2:0]  r_bit;
    logic [7:0]  r_shift;
    logic [7:0]  r_data;
    logic        r_wr;
    logic        r_ferr;

    state_t      w_state_nx;
    logic [23:0] w_cnt_nx;
    logic [2:0]  w_bit_nx;
    logic [7:0]  w_shift_nx;
    logic [7:0]  w_data_nx;
    logic        w_wr_nx;
    logic        w_ferr_nx;
    logic        w_period_end;

    assign w_period_end = (r_cnt == 24'd0);

    // Two-flop synchronizer; resets to the idle (high) line level
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= i_uart_rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // Next-state, counter, shift register and strobe decisions
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_bit_nx   = r_bit;
        w_shift_nx = r_shift;
        w_data_nx  = r_data;
        w_wr_nx    = 1'b0;
        w_ferr_nx  = 1'b0;

        case (r_state)
            IDLE: begin
                if (!r_rx_s) begin
                    w_state_nx = START;
                    w_cnt_nx   = LP_HALF_M1;
                end
            end

            START: begin
                if (w_period_end) begin
                    if (!r_rx_s) begin
                        w_state_nx = DATA;
                        w_cnt_nx   = LP_BAUD_M1;
                        w_bit_nx   = 3'd0;
                    end else begin
                        // Start bit vanished by mid-bit: treat as a glitch
                        w_state_nx = IDLE;
                    end
                end else begin
                    w_cnt_nx = r_cnt - 24'd1;
                end
            end

            DATA: begin
                if (w_period_end) begin
                    w_shift_nx = {r_rx_s, r_shift[7:1]};
                    w_cnt_nx   = LP_BAUD_M1;
                    w_bit_nx   = r_bit + 3'd1;
                    if (r_bit == LP_LAST_BIT) begin
                        w_state_nx = STOP;
                    end
                end else begin
                    w_cnt_nx = r_cnt - 24'd1;
                end
            end

            STOP: begin
                if (w_period_end) begin
                    if (r_rx_s) begin
                        w_data_nx  = r_shift;
                        w_wr_nx    = 1'b1;
                        w_state_nx = IDLE;
                    end else begin
                        w_ferr_nx  = 1'b1;
                        w_state_nx = WAIT_IDLE;
                    end
                end else begin
                    w_cnt_nx = r_cnt - 24'd1;
                end
            end

            WAIT_IDLE: begin
                // Hold off through a break so it reports only one error
                if (r_rx_s) begin
                    w_state_nx = IDLE;
                end
            end

            default: begin
                w_state_nx = IDLE;
                w_cnt_nx   = 24'd0;
            end
        endcase
    end

    // Receiver state and registered outputs
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= IDLE;
            r_cnt   <= 24'd0;
            r_bit   <= 3'd0;
            r_shift <= 8'h00;
            r_data  <= 8'h00;
            r_wr    <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_bit   <= w_bit_nx;
            r_shift <= w_shift_nx;
            r_data  <= w_data_nx;
            r_wr    <= w_wr_nx;
            r_ferr  <= w_ferr_nx;
        end
    end

    assign o_wr        = r_wr;
    assign o_data      = r_data;
    assign o_frame_err = r_ferr;
    assign o_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_lite.sv
// Scoreboard bench for uart_rx_lite: one instance at 16 clocks/bit and one
// at the default baud, each with its own expected-response queue.
module tb_uart_rx_lite;

    localparam int CPB16   = 16;
    localparam int CPB_DEF = 868;

    typedef struct {
        bit         ferr;
        logic [7:0] data;
        int         t;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx16 = 1'b1;
    logic       rx_def = 1'b1;
    logic       wr16, ferr16, busy16;
    logic [7:0] data16;
    logic       wr_def, ferr_def, busy_def;
    logic [7:0] data_def;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t q16[$];
    exp_t qdef[$];
    logic [7:0] model_last16 = 8'h00;
    logic [7:0] model_last_def = 8'h00;
    logic [7:0] prev_data16 = 8'h00;

    uart_rx_lite #(.CLOCKS_PER_BAUD(24'd16)) dut16 (
        .i_clk(clk), .i_reset_n(rst_n), .i_uart_rx(rx16),
        .o_wr(wr16), .o_data(data16), .o_frame_err(ferr16), .o_busy(busy16)
    );

    uart_rx_lite dut_def (
        .i_clk(clk), .i_reset_n(rst_n), .i_uart_rx(rx_def),
        .o_wr(wr_def), .o_data(data_def), .o_frame_err(ferr_def), .o_busy(busy_def)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d (0x%0h) expected=%0d (0x%0h) cyc=%0d",
                     nm, act, act, exp, exp, cyc);
        end
    endtask

    task automatic set_line(input bit sel, input logic v);
        if (sel) rx_def = v;
        else     rx16 = v;
    endtask

    // Drive nbits of an 8N1 frame (start, d0..d7, stop) with a bit length of
    // len100/100 clocks; optionally record the expected receiver response.
    task automatic send_bits(input bit sel, input logic [7:0] d, input logic stop_v,
                             input int len100, input int nbits, input bit push);
        int   elapsed;
        int   t0;
        int   cpb;
        exp_t e;
        logic v;
        elapsed = 0;
        cpb = sel ? CPB_DEF : CPB16;
        @(negedge clk);
        t0 = cyc + 1;
        if (push) begin
            e.ferr = !stop_v;
            if (stop_v) begin
                e.data = d;
                if (sel) model_last_def = d;
                else     model_last16 = d;
            end else begin
                e.data = sel ? model_last_def : model_last16;
            end
            e.t = (len100 == cpb * 100) ? t0 + 2 + cpb / 2 + 9 * cpb : -1;
            if (sel) qdef.push_back(e);
            else     q16.push_back(e);
        end
        for (int b = 0; b < nbits; b++) begin
            if (b == 0)      v = 1'b0;
            else if (b <= 8) v = d[b-1];
            else             v = stop_v;
            set_line(sel, v);
            while (elapsed < ((b + 1) * len100) / 100) begin
                @(negedge clk);
                elapsed++;
            end
        end
    endtask

    task automatic drain(input string nm, input int limit);
        int n;
        n = 0;
        while ((q16.size() != 0 || qdef.size() != 0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_pending"}, q16.size() + qdef.size(), 0);
    endtask

    // Monitor for the 16 clocks/bit instance
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (wr16 || ferr16) begin
                chk("wr_ferr_exclusive", int'(wr16 && ferr16), 0);
                if (q16.size() == 0) begin
                    chk("unexpected_strobe16", 1, 0);
                end else begin
                    e = q16.pop_front();
                    chk("kind16_ferr", int'(ferr16), int'(e.ferr));
                    chk("data16", int'(data16), int'(e.data));
                    if (e.t >= 0) chk("time16", cyc, e.t);
                end
            end else if (data16 !== prev_data16) begin
                chk("data16_hold", int'(data16), int'(prev_data16));
            end
        end
        prev_data16 = data16;
    end

    // Monitor for the default-baud instance
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (wr_def || ferr_def)) begin
            if (qdef.size() == 0) begin
                chk("unexpected_strobe_def", 1, 0);
            end else begin
                e = qdef.pop_front();
                chk("kind_def_ferr", int'(ferr_def), int'(e.ferr));
                chk("data_def", int'(data_def), int'(e.data));
                if (e.t >= 0) chk("time_def", cyc, e.t);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt;
        int len;
        logic [7:0] d;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_wr", int'(wr16), 0);
        chk("rst_data", int'(data16), 0);
        chk("rst_ferr", int'(ferr16), 0);
        chk("rst_busy", int'(busy16), 0);
        chk("rst_busy_def", int'(busy_def), 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_busy", int'(busy16), 0);

        // 0x55 at the default baud
        send_bits(1'b1, 8'h55, 1'b1, CPB_DEF * 100, 10, 1'b1);
        drain("def55", 200);
        repeat (20) @(negedge clk);

        // Back-to-back frames at exact baud
        send_bits(1'b0, 8'hA3, 1'b1, 1600, 10, 1'b1);
        send_bits(1'b0, 8'h00, 1'b1, 1600, 10, 1'b1);
        send_bits(1'b0, 8'hFF, 1'b1, 1600, 10, 1'b1);
        drain("b2b", 100);
        repeat (10) @(negedge clk);

        // 5-cycle glitch on the idle line
        busy_cnt = 0;
        rx16 = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i == 4) rx16 = 1'b1;
            busy_cnt += int'(busy16);
        end
        chk("glitch_busy_cycles", busy_cnt, CPB16 / 2);
        chk("glitch_idle", int'(busy16), 0);

        // Stop bit low, then the line held low (break)
        send_bits(1'b0, 8'h3C, 1'b0, 1600, 10, 1'b1);
        repeat (300) @(negedge clk);
        drain("ferr", 10);
        chk("break_busy", int'(busy16), 1);
        rx16 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("break_busy_r1", int'(busy16), 1);
        @(negedge clk);
        chk("break_busy_r2", int'(busy16), 0);
        repeat (10) @(negedge clk);

        // Reset pulse during data bit 4 of 0xC7 aborts the frame
        send_bits(1'b0, 8'hC7, 1'b1, 1600, 5, 1'b0);
        rx16 = 1'b0;
        repeat (8) @(negedge clk);
        chk("pre_reset_busy", int'(busy16), 1);
        rst_n = 1'b0;
        q16.delete();
        qdef.delete();
        model_last16 = 8'h00;
        model_last_def = 8'h00;
        @(negedge clk);
        chk("midrst_busy", int'(busy16), 0);
        chk("midrst_data", int'(data16), 0);
        chk("midrst_wr", int'(wr16), 0);
        rx16 = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("post_rst_busy", int'(busy16), 0);
        send_bits(1'b0, 8'h81, 1'b1, 1600, 10, 1'b1);
        drain("after_rst", 100);
        repeat (10) @(negedge clk);

        // Random bytes with the sender up to 2% off nominal baud
        for (int k = 0; k < 16; k++) begin
            d = 8'($urandom_range(0, 255));
            case ($urandom_range(0, 2))
                0:       len = 1568;
                1:       len = 1600;
                default: len = 1632;
            endcase
            send_bits(1'b0, d, 1'b1, len, 10, 1'b1);
            repeat ($urandom_range(0, 12)) @(negedge clk);
        end
        drain("random", 200);
        repeat (20) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
